// File: rtl/e_mdu.sv
// e_mdu: execute-stage multiply/divide unit owning HI/LO.
// Result is computed from the operands sampled at accept and parked in a
// pending register; a down-counter models the multi-cycle latency and the
// pending value is committed to HI/LO on the last busy edge.
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;   // divide by zero: occupy the unit but leave HI/LO alone
  } mdu_res_t;

  logic [CW-1:0] cnt;
  mdu_res_t      pend;
  mdu_res_t      res_c;
  logic          acc;

  // flush wins over start; stall unit guarantees no start while busy,
  // but a stray one is dropped rather than queued
  assign busy = (cnt != '0);
  assign acc  = start && !req && !busy && (op inside {[OP_MULT:OP_MTLO]});

  logic        is_signed_div;
  logic        sa, sb;
  logic [31:0] ua, ub, ub_safe, q_u, r_u;
  logic [63:0] prod_s, prod_u;

  // result datapath: full 64-bit product and sign-magnitude division so
  // 0x80000000 / -1 yields 0x80000000 / 0 without relying on signed overflow
  always_comb begin
    prod_s        = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    prod_u        = {32'd0, a} * {32'd0, b};
    is_signed_div = (op == OP_DIV);
    sa            = is_signed_div & a[31];
    sb            = is_signed_div & b[31];
    ua            = sa ? (~a + 32'd1) : a;
    ub            = sb ? (~b + 32'd1) : b;
    ub_safe       = (b == 32'd0) ? 32'd1 : ub;
    q_u           = ua / ub_safe;
    r_u           = ua % ub_safe;
    res_c         = '0;
    unique case (op)
      OP_MULT:  res_c = '{hi: prod_s[63:32], lo: prod_s[31:0], dz: 1'b0};
      OP_MULTU: res_c = '{hi: prod_u[63:32], lo: prod_u[31:0], dz: 1'b0};
      OP_DIV, OP_DIVU: begin
        res_c.lo = (sa ^ sb) ? (~q_u + 32'd1) : q_u;
        res_c.hi = sa ? (~r_u + 32'd1) : r_u;
        res_c.dz = (b == 32'd0);
      end
      default: res_c = '0;
    endcase
  end

  // latency counter, pending result capture, and HI/LO update
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      pend <= '0;
      hi   <= '0;
      lo   <= '0;
    end else if (acc) begin
      unique case (op)
        OP_MULT, OP_MULTU: begin
          cnt  <= CW'(MULT_CYCLES);
          pend <= res_c;
        end
        OP_DIV, OP_DIVU: begin
          cnt  <= CW'(DIV_CYCLES);
          pend <= res_c;
        end
        OP_MTHI: hi <= a;
        default: lo <= a;   // mtlo
      endcase
    end else if (busy) begin
      // an in-flight op is older than any flushed instruction, so req
      // does not touch it
      cnt <= cnt - 1'b1;
      if (cnt == CW'(1) && !pend.dz) begin
        hi <= pend.hi;
        lo <= pend.lo;
      end
    end
  end

endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu: directed vectors with hand-computed HI/LO results and busy lengths.
module tb_e_mdu;

  logic        clk = 1'b0;
  logic        reset, req, start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy;
  logic [31:0] hi, lo;

  int n_cmp = 0;
  int n_err = 0;

  e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .req(req), .start(start), .op(op),
    .a(a), .b(b), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // present an op for one cycle; afterwards operands are scrambled to prove capture
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    op = o; a = x; b = y; start = 1'b1;
    step();
    start = 1'b0; op = 3'd0; a = $urandom; b = $urandom;
  endtask

  // count busy cycles until idle, bounded
  task automatic drain(output int n);
    n = 0;
    while (busy && n < 64) begin
      n++;
      step();
    end
  endtask

  int n;

  initial begin
    reset = 1'b1; req = 1'b0; start = 1'b0; op = 3'd0; a = '0; b = '0;
    step(); step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    reset = 1'b0;

    // mult -1 * 2
    issue(3'd1, 32'hFFFF_FFFF, 32'd2);
    drain(n);
    chk("mult_cycles", 32'(n), 32'd5);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFE);

    // multu 0xFFFFFFFF * 2
    issue(3'd2, 32'hFFFF_FFFF, 32'd2);
    drain(n);
    chk("multu_cycles", 32'(n), 32'd5);
    chk("multu_hi", hi, 32'h0000_0001);
    chk("multu_lo", lo, 32'hFFFF_FFFE);

    // div -7 / 2 = -3 rem -1
    issue(3'd3, 32'hFFFF_FFF9, 32'd2);
    drain(n);
    chk("div_cycles", 32'(n), 32'd10);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);

    // divu 7 / 0: full latency, HI/LO unchanged
    issue(3'd4, 32'd7, 32'd0);
    drain(n);
    chk("divz_cycles", 32'(n), 32'd10);
    chk("divz_lo", lo, 32'hFFFF_FFFD);
    chk("divz_hi", hi, 32'hFFFF_FFFF);

    // mthi / mtlo
    issue(3'd5, 32'h1234_5678, 32'd0);
    chk("mthi_busy", 32'(busy), 32'd0);
    chk("mthi_hi", hi, 32'h1234_5678);
    chk("mthi_lo", lo, 32'hFFFF_FFFD);
    issue(3'd6, 32'hCAFE_F00D, 32'd0);
    chk("mtlo_busy", 32'(busy), 32'd0);
    chk("mtlo_lo", lo, 32'hCAFE_F00D);
    chk("mtlo_hi", hi, 32'h1234_5678);

    // signed overflow case 0x80000000 / -1
    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    drain(n);
    chk("ovf_lo", lo, 32'h8000_0000);
    chk("ovf_hi", hi, 32'h0000_0000);

    // start coincident with flush is dropped
    req = 1'b1;
    issue(3'd1, 32'd3, 32'd3);
    req = 1'b0;
    chk("req_busy", 32'(busy), 32'd0);
    step();
    chk("req_busy2", 32'(busy), 32'd0);
    chk("req_hi", hi, 32'h0000_0000);
    chk("req_lo", lo, 32'h8000_0000);

    // illegal/none opcodes with start: no change
    issue(3'd7, 32'h5555_5555, 32'd1);
    chk("op7_busy", 32'(busy), 32'd0);
    chk("op7_lo", lo, 32'h8000_0000);
    issue(3'd0, 32'h5555_5555, 32'd1);
    chk("op0_busy", 32'(busy), 32'd0);
    chk("op0_hi", hi, 32'h0000_0000);

    // div -100 / 7 = -14 rem -2, flush at busy cycle 3 does not cancel it
    issue(3'd3, 32'hFFFF_FF9C, 32'd7);
    step(); step();
    req = 1'b1;
    step();
    req = 1'b0;
    drain(n);
    chk("divreq_rest", 32'(n), 32'd7);
    chk("divreq_lo", lo, 32'hFFFF_FFF2);
    chk("divreq_hi", hi, 32'hFFFF_FFFE);

    // start while busy is ignored and does not restart the counter
    issue(3'd1, 32'd3, 32'd4);
    step();
    issue(3'd2, 32'd5, 32'd6);
    drain(n);
    chk("overlap_rest", 32'(n), 32'd3);
    chk("overlap_lo", lo, 32'd12);
    chk("overlap_hi", hi, 32'd0);

    // reset in the middle of a divide
    issue(3'd6, 32'hDEAD_BEEF, 32'd0);
    issue(3'd3, 32'd100, 32'd7);
    step(); step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_hi", hi, 32'd0);
    chk("rstmid_lo", lo, 32'd0);
    step();
    chk("rstmid_busy2", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
